// File: rtl/keypad_scan_ctrl_if.sv
// Key delivery channel between the keypad scanner (master) and the processor (slave).
// key_valid rises with key_code loaded and holds both until a one-cycle key_ack; ack with key_valid low is ignored.
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overflow;

  modport master (output key_code, output key_valid, output overflow, input key_ack);
  modport slave  (input key_code, input key_valid, input overflow, output key_ack);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 3x4 keypad scanner with press/release debounce and valid/ack key delivery.
// Optional auto-repeat of a held key is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int CLK_DIV        = 500000,
  parameter int SETTLE         = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 100,
  parameter int REPEAT_PERIOD  = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         cols,
  output logic [3:0]         rows,
  output logic [1:0]         fsm_state,
  keypad_scan_ctrl_if.master key
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  localparam int DW = $clog2(CLK_DIV);
  localparam int M1 = (SETTLE > DEBOUNCE_TICKS) ? SETTLE : DEBOUNCE_TICKS;
  localparam int M2 = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(CNT_MAX + 1);

  state_t         state_q, state_d;
  logic [DW-1:0]  div_cnt;
  logic [CW-1:0]  cnt;
  logic [1:0]     row_q;
  logic [2:0]     pat_q;
  logic [3:0]     code_q;
  logic           tick, all_high, one_low, settle_done, db_done, pat_match;
  logic           latch, row_adv, cnt_clr, cnt_inc, emit;

  assign tick        = (div_cnt == DW'(CLK_DIV - 1));
  assign all_high    = (cols == 3'b111);
  assign one_low     = (cols == 3'b110) || (cols == 3'b101) || (cols == 3'b011);
  assign settle_done = (cnt == CW'(SETTLE - 1));
  assign db_done     = (cnt == CW'(DEBOUNCE_TICKS - 1));
  assign pat_match   = (cols == pat_q);
  assign fsm_state   = state_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic rep_first;
  logic rep_hit;
  assign rep_hit = rep_first ? (cnt == CW'(REPEAT_DELAY - 1)) : (cnt == CW'(REPEAT_PERIOD - 1));
`endif

  // Row 3 holds '*', '0', '#' in column order.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [2:0] c);
    logic [3:0] ci;
    ci = (c == 3'b110) ? 4'd0 : (c == 3'b101) ? 4'd1 : 4'd2;
    case (r)
      2'd0:    map_key = 4'd1 + ci;
      2'd1:    map_key = 4'd4 + ci;
      2'd2:    map_key = 4'd7 + ci;
      default: map_key = (ci == 4'd0) ? 4'd10 : (ci == 4'd1) ? 4'd0 : 4'd11;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= SCAN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        SCAN:     if (settle_done && one_low) state_d = DB_PRESS;
        DB_PRESS: if (!pat_match) state_d = SCAN;
                  else if (db_done) state_d = HELD;
        HELD:     if (all_high) state_d = DB_REL;
        default:  if (!all_high) state_d = HELD;
                  else if (db_done) state_d = SCAN;
      endcase
    end
  end

  always_comb begin
    latch   = 1'b0;
    row_adv = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    emit    = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (!settle_done) cnt_inc = 1'b1;
          else begin
            cnt_clr = 1'b1;
            if (one_low) latch = 1'b1;
            else         row_adv = 1'b1;
          end
        end
        DB_PRESS: begin
          if (!pat_match) cnt_clr = 1'b1;
          else if (db_done) begin
            emit    = 1'b1;
            cnt_clr = 1'b1;
          end else cnt_inc = 1'b1;
        end
        HELD: begin
          if (all_high) cnt_clr = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_hit) begin
            emit    = 1'b1;
            cnt_clr = 1'b1;
          end else cnt_inc = 1'b1;
`endif
        end
        default: begin
          if (!all_high) cnt_clr = 1'b1;
          else if (db_done) begin
            cnt_clr = 1'b1;
            row_adv = 1'b1;
          end else cnt_inc = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt       <= '0;
      cnt           <= '0;
      row_q         <= 2'd0;
      rows          <= 4'b1110;
      pat_q         <= 3'b111;
      code_q        <= 4'hD;
      key.key_code  <= 4'hD;
      key.key_valid <= 1'b0;
      key.overflow  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      // Rotating the single zero keeps exactly one row driven, including the 3->0 wrap.
      if (row_adv) begin
        row_q <= row_q + 2'd1;
        rows  <= {rows[2:0], rows[3]};
      end
      if (latch) begin
        pat_q  <= cols;
        code_q <= map_key(row_q, cols);
      end
      if (emit) begin
        if (!key.key_valid || key.key_ack) begin
          key.key_code  <= code_q;
          key.key_valid <= 1'b1;
          if (key.key_valid) key.overflow <= 1'b0;
        end else begin
          key.overflow <= 1'b1;
        end
      end else if (key.key_ack && key.key_valid) begin
        key.key_valid <= 1'b0;
        key.key_code  <= 4'hD;
        key.overflow  <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  rep_first <= 1'b1;
    else if (state_q != HELD)    rep_first <= 1'b1;
    else if (emit)               rep_first <= 1'b0;
  end
`endif

endmodule
